// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 register target.
package spi_target_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int CNT_W      = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA
  } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// N-stage synchronizer for one asynchronous input, with rise/fall detection
// on the synchronized value.
module spi_target_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [N-1:0] chain;
  logic         prev;

  // NOTE: non-blocking assignments so each stage captures the previous
  // stage's value from before this edge, giving a true N-flop pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[N-2:0], d};
      prev  <= chain[N-1];
    end
  end

  assign q    = chain[N-1];
  assign rise = chain[N-1] & ~prev;
  assign fall = ~chain[N-1] & prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled SCLK/CSN/MOSI, byte-framed command protocol
// bridged to a byte-wide local register bus with auto-incrementing address.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_csn,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [BYTE_W-1:0] rd_data,
  output logic              frame_err
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  logic csn_s, csn_rise, csn_fall;
  logic sclk_q_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_target_sync #(.N(SYNC_STAGES)) u_sync_csn (
    .clk(clk), .rst(rst), .d(spi_csn),
    .q(csn_s), .rise(csn_rise), .fall(csn_fall)
  );

  spi_target_sync #(.N(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi_sclk),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_target_sync #(.N(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t            state_q, state_d;
  logic              armed;
  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-2:0] rx_sr;
  logic [BYTE_W-1:0] tx_sr;
  logic [ADDR_W-1:0] addr;
  logic              rd_load;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_done;

  // The byte being completed includes the MOSI bit sampled on this rise.
  assign byte_in   = {rx_sr, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == LAST_BIT) && (state_q != ST_IDLE);

  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (csn_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (csn_fall && armed) state_d = ST_CMD;
        ST_CMD:  if (byte_done) state_d = byte_in[CMD_RW_BIT] ? ST_RDATA : ST_WDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed       <= 1'b0;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      addr        <= '0;
      rd_load     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      frame_err   <= 1'b0;
    end else begin
      wr_valid    <= 1'b0;
      rd_req      <= 1'b0;
      rd_load     <= rd_req;
      spi_miso_oe <= armed & ~csn_s;
      if (csn_s) armed <= 1'b1;

      if (state_q != ST_IDLE && sclk_rise) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        rx_sr   <= byte_in[BYTE_W-2:0];
      end

      if (csn_rise) begin
        // A byte finishing on the same cycle as deselect still commits.
        bit_cnt  <= '0;
        spi_miso <= 1'b0;
        if (bit_cnt != '0 && !byte_done) frame_err <= 1'b1;
        if (state_q == ST_WDATA && byte_done) begin
          wr_valid <= 1'b1;
          wr_addr  <= addr;
          wr_data  <= byte_in;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (csn_fall && armed) begin
              bit_cnt   <= '0;
              frame_err <= 1'b0;
            end
          end
          ST_CMD: begin
            if (byte_done) begin
              addr <= byte_in[ADDR_W-1:0];
              if (byte_in[CMD_RW_BIT]) begin
                rd_req  <= 1'b1;
                rd_addr <= byte_in[ADDR_W-1:0];
              end
            end
          end
          ST_WDATA: begin
            if (byte_done) begin
              wr_valid <= 1'b1;
              wr_addr  <= addr;
              wr_data  <= byte_in;
              addr     <= addr + ADDR_W'(1);
            end
          end
          ST_RDATA: begin
            if (sclk_fall) begin
              spi_miso <= tx_sr[BYTE_W-1];
              tx_sr    <= {tx_sr[BYTE_W-2:0], 1'b0};
            end
            // Prefetch the next byte so it is loaded before the boundary fall.
            if (byte_done) begin
              addr    <= addr + ADDR_W'(1);
              rd_req  <= 1'b1;
              rd_addr <= addr + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end

      if (rd_load) tx_sr <= rd_data;
    end
  end

endmodule
